seven_seg_ext: RTL

- Parametrised next-generation multiplexed seven-segment driver for an AN_COUNT-digit common-anode display.
- Scans one digit per refresh tick and drives active-low anodes, cathodes and decimal point.
- Adds a refresh prescaler, PWM brightness, per-digit blink, per-digit decimal point and leading-zero suppression.
- Sits between the numeric datapath (packed hex NUMBER) and the board display pins.

---
 rtl/seven_seg_ext_if.sv | 31 +++
 rtl/seven_seg_ext.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seven_seg_ext_if.sv
// Display-side bus of seven_seg_ext: scan control and per-digit inputs from the
// datapath, registered anode/segment/decimal-point pins back to the board.
interface seven_seg_ext_if #(
    parameter int AN_COUNT     = 8,
    parameter int DIGIT_SIZE   = 4,
    parameter int CATH_COUNT   = 7,
    parameter int BRIGHT_WIDTH = 3,
    parameter int IDX_WIDTH    = (AN_COUNT > 1) ? $clog2(AN_COUNT) : 1
);
    logic                             CE;
    logic [AN_COUNT*DIGIT_SIZE-1:0]   NUMBER;
    logic [AN_COUNT-1:0]              AN_MASK;
    logic [AN_COUNT-1:0]              DP_IN;
    logic [AN_COUNT-1:0]              BLINK_MASK;
    logic                             LZ_EN;
    logic [BRIGHT_WIDTH-1:0]          BRIGHT;
    logic [AN_COUNT-1:0]              AN;
    logic [CATH_COUNT-1:0]            CATH;
    logic                             DP;
    logic [IDX_WIDTH-1:0]             DIGIT_IDX;

    modport master (
        output CE, NUMBER, AN_MASK, DP_IN, BLINK_MASK, LZ_EN, BRIGHT,
        input  AN, CATH, DP, DIGIT_IDX
    );

    modport slave (
        input  CE, NUMBER, AN_MASK, DP_IN, BLINK_MASK, LZ_EN, BRIGHT,
        output AN, CATH, DP, DIGIT_IDX
    );
endinterface

// File: rtl/seven_seg_ext.sv
// Multiplexed common-anode seven-segment driver with refresh prescaler, PWM
// brightness, per-digit blink/decimal point and leading-zero suppression.
module seven_seg_ext #(
    parameter int AN_COUNT     = 8,
    parameter int DIGIT_SIZE   = 4,
    parameter int CATH_COUNT   = 7,
    parameter int PRESCALE     = 1,
    parameter int BRIGHT_WIDTH = 3,
    parameter int BLINK_WIDTH  = 4
) (
    input  logic          clk,
    input  logic          RESET_N,
    seven_seg_ext_if.slave bus
);
    localparam int IDX_W = $clog2(AN_COUNT);
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(AN_COUNT - 1);
    localparam logic [PS_W-1:0]  LAST_PS  = PS_W'(PRESCALE - 1);

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'h0:    code = 7'b1000000;
            4'h1:    code = 7'b1111001;
            4'h2:    code = 7'b0100100;
            4'h3:    code = 7'b0110000;
            4'h4:    code = 7'b0011001;
            4'h5:    code = 7'b0010010;
            4'h6:    code = 7'b0000010;
            4'h7:    code = 7'b1111000;
            4'h8:    code = 7'b0000000;
            4'h9:    code = 7'b0010000;
            4'hA:    code = 7'b0001000;
            4'hB:    code = 7'b0000011;
            4'hC:    code = 7'b1000110;
            4'hD:    code = 7'b0100001;
            4'hE:    code = 7'b0000110;
            4'hF:    code = 7'b0001110;
            default: code = 7'b1111111;
        endcase
        return code;
    endfunction

    logic [IDX_W-1:0]        digit_idx_r;
    logic [PS_W-1:0]         prescale_cnt_r;
    logic [BRIGHT_WIDTH-1:0] pwm_cnt_r;
    logic [BLINK_WIDTH-1:0]  blink_cnt_r;
    logic [AN_COUNT-1:0]     an_r;
    logic [CATH_COUNT-1:0]   cath_r;
    logic                    dp_r;
    logic [IDX_W-1:0]        digit_idx_out_r;

    logic [DIGIT_SIZE-1:0]   digit_val_s;
    logic                    upper_zero_s;
    logic                    lz_blank_s;
    logic                    pwm_on_s;
    logic                    blink_off_s;
    logic                    digit_en_s;
    logic [AN_COUNT-1:0]     an_s;
    logic [CATH_COUNT-1:0]   cath_s;
    logic                    dp_s;
    logic [IDX_W-1:0]        digit_idx_next_s;
    logic [PS_W-1:0]         prescale_cnt_next_s;

    // Select the current digit and decide whether leading-zero suppression blanks it
    always_comb begin
        digit_val_s  = {DIGIT_SIZE{1'b0}};
        upper_zero_s = 1'b1;
        lz_blank_s   = 1'b0;
        // Walk from the most significant digit down so upper_zero_s covers digits top..i
        for (int i = AN_COUNT - 1; i >= 0; i--) begin
            upper_zero_s = upper_zero_s & (bus.NUMBER[i*DIGIT_SIZE +: DIGIT_SIZE] == {DIGIT_SIZE{1'b0}});
            digit_val_s  = (digit_idx_r == IDX_W'(i)) ? bus.NUMBER[i*DIGIT_SIZE +: DIGIT_SIZE] : digit_val_s;
            lz_blank_s   = (digit_idx_r == IDX_W'(i)) ? (bus.LZ_EN & upper_zero_s & (i != 0)) : lz_blank_s;
        end
    end

    // Enable decision and the output word to load for the current digit
    always_comb begin
        pwm_on_s    = (pwm_cnt_r <= bus.BRIGHT);
        blink_off_s = bus.BLINK_MASK[digit_idx_r] & blink_cnt_r[BLINK_WIDTH-1];
        digit_en_s  = ~bus.AN_MASK[digit_idx_r] & pwm_on_s & ~blink_off_s & ~lz_blank_s;
        if (digit_en_s) begin
            an_s   = ~({{(AN_COUNT-1){1'b0}}, 1'b1} << digit_idx_r);
            cath_s = seg_decode(digit_val_s);
            dp_s   = ~bus.DP_IN[digit_idx_r];
        end else begin
            an_s   = {AN_COUNT{1'b1}};
            cath_s = {CATH_COUNT{1'b1}};
            dp_s   = 1'b1;
        end
    end

    // Slot timing: hold each digit for PRESCALE enabled cycles, then advance with wrap
    always_comb begin
        if (prescale_cnt_r == LAST_PS) begin
            prescale_cnt_next_s = {PS_W{1'b0}};
            if (digit_idx_r == LAST_IDX) begin
                digit_idx_next_s = {IDX_W{1'b0}};
            end else begin
                digit_idx_next_s = digit_idx_r + IDX_W'(1);
            end
        end else begin
            prescale_cnt_next_s = prescale_cnt_r + PS_W'(1);
            digit_idx_next_s    = digit_idx_r;
        end
    end

    // Scan state and registered pins; reset wins over CE, CE low freezes everything
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            digit_idx_r     <= {IDX_W{1'b0}};
            prescale_cnt_r  <= {PS_W{1'b0}};
            pwm_cnt_r       <= {BRIGHT_WIDTH{1'b0}};
            blink_cnt_r     <= {BLINK_WIDTH{1'b0}};
            an_r            <= {AN_COUNT{1'b1}};
            cath_r          <= {CATH_COUNT{1'b1}};
            dp_r            <= 1'b1;
            digit_idx_out_r <= {IDX_W{1'b0}};
        end else if (bus.CE) begin
            digit_idx_r     <= digit_idx_next_s;
            prescale_cnt_r  <= prescale_cnt_next_s;
            pwm_cnt_r       <= pwm_cnt_r + BRIGHT_WIDTH'(1);
            blink_cnt_r     <= blink_cnt_r + BLINK_WIDTH'(1);
            an_r            <= an_s;
            cath_r          <= cath_s;
            dp_r            <= dp_s;
            digit_idx_out_r <= digit_idx_r;
        end
    end

    assign bus.AN        = an_r;
    assign bus.CATH      = cath_r;
    assign bus.DP        = dp_r;
    assign bus.DIGIT_IDX = digit_idx_out_r;
endmodule
